fifo_apb_ctrl: RTL and testbench

APB slave controller that sequences the byte FIFO on behalf of the RISC-V core: it turns register accesses into single-cycle FIFO push/pop strobes, tracks occupancy and raises an interrupt. It sits between the APB interconnect and one `fifo` instance, and is that instance's only driver.

---
 rtl/fifo_apb_ctrl_if.sv | 22 ++
 rtl/fifo_apb_ctrl.sv | 137 +++++++++++++
 tb/tb_fifo_apb_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_apb_ctrl_if.sv
// APB3 slave-side bus bundle for the FIFO controller.
// Master drives address/control/write data; slave returns read data and ready.
// Signal names follow the APB interconnect naming used across the SoC.
interface fifo_apb_ctrl_if;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/fifo_apb_ctrl.sv
// APB slave that turns register accesses into byte-FIFO push/pop strobes, tracks level, raises irq.
// Latency: every access takes one wait state; strobes fire in the single RESP cycle, irq lags state by one edge.
// Backpressure: full FIFO turns a push into a sticky OVF, empty FIFO turns a pop into a sticky UDF; APB never stalls longer.
module fifo_apb_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  fifo_apb_ctrl_if.slave   apb,
  output logic [7:0]       fifo_wdata,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_rd_en,
  input  logic             fifo_empty,
  output logic             irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic          en;
  logic          irq_en;
  logic [4:0]    thresh;
  logic          ovf;
  logic          udf;
  logic [LW-1:0] level;
  logic [31:0]   prdata;
  logic          pready;

  logic [1:0]  sel;
  logic        access;
  logic        tx_wr;
  logic        rx_rd;
  logic        do_push;
  logic        do_pop;
  logic        ovf_set;
  logic        udf_set;
  logic        level_hit;
  logic [31:0] rd_mux;

  // Byte lanes and address bits below the word are never decoded.
  logic unused_bits;
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:9]};

  assign sel     = apb.PADDR[3:2];
  assign access  = apb.PSEL & apb.PENABLE;
  assign tx_wr   = access &  apb.PWRITE & (sel == REG_TXDATA) & en;
  assign rx_rd   = access & ~apb.PWRITE & (sel == REG_RXDATA) & en;
  assign do_push = tx_wr & ~fifo_full;
  assign ovf_set = tx_wr &  fifo_full;
  assign do_pop  = rx_rd & ~fifo_empty;
  assign udf_set = rx_rd &  fifo_empty;

  // THRESH of zero switches the level term off entirely.
  assign level_hit = (thresh != 5'd0) && (32'(level) >= 32'(thresh));

  assign apb.PRDATA = prdata;
  assign apb.PREADY = pready;

  // Read-data selection; STATUS flags empty/full are live from the FIFO.
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL:   rd_mux = {23'b0, thresh, 2'b0, irq_en, en};
      REG_STATUS: rd_mux = (32'(level) << 4) | {28'b0, udf, ovf, fifo_full, fifo_empty};
      REG_TXDATA: rd_mux = '0;
      REG_RXDATA: if (en && !fifo_empty) rd_mux = {24'b0, fifo_rdata};
      default:    rd_mux = '0;
    endcase
  end

  // Access sequencer: register side effects land on the IDLE->RESP edge, strobes live only in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prdata     <= '0;
      pready     <= 1'b0;
      fifo_wdata <= '0;
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      irq        <= 1'b0;
      en         <= 1'b0;
      irq_en     <= 1'b0;
      thresh     <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      level      <= '0;
    end else begin
      irq <= irq_en & (ovf | udf | level_hit);
      case (state)
        IDLE: begin
          if (access) begin
            state  <= RESP;
            pready <= 1'b1;
            prdata <= apb.PWRITE ? 32'd0 : rd_mux;
            if (apb.PWRITE && sel == REG_CTRL) begin
              en     <= apb.PWDATA[0];
              irq_en <= apb.PWDATA[1];
              thresh <= apb.PWDATA[8:4];
            end
            if (apb.PWRITE && sel == REG_STATUS) begin
              if (apb.PWDATA[2]) ovf <= 1'b0;
              if (apb.PWDATA[3]) udf <= 1'b0;
            end
            if (do_push) begin
              fifo_wr_en <= 1'b1;
              fifo_wdata <= apb.PWDATA[7:0];
              level      <= level + LW'(1);
            end
            if (do_pop) begin
              fifo_rd_en <= 1'b1;
              level      <= level - LW'(1);
            end
            if (ovf_set) ovf <= 1'b1;
            if (udf_set) udf <= 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          pready     <= 1'b0;
          fifo_wr_en <= 1'b0;
          fifo_rd_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_apb_ctrl.sv
// Self-checking bench for fifo_apb_ctrl: directed scenarios then random APB traffic.
// A queue-based byte FIFO stands in for the real FIFO; a register-level model predicts every response.
module tb_fifo_apb_ctrl;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_apb_ctrl_if apb();
  logic [7:0] fifo_wdata;
  logic       fifo_wr_en;
  logic       fifo_full = 1'b0;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd_en;
  logic       fifo_empty = 1'b1;
  logic       irq;

  fifo_apb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .apb        (apb),
    .fifo_wdata (fifo_wdata),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .irq        (irq)
  );

  // Stand-in byte FIFO, sharing the controller's reset.
  logic [7:0] fq[$];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq.delete();
    end else begin
      if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_wdata);
      if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
    end
    fifo_full  <= (fq.size() == DEPTH);
    fifo_empty <= (fq.size() == 0);
    fifo_rdata <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // Register-level reference model.
  int m_en, m_ien, m_thresh, m_ovf, m_udf;
  logic [7:0] m_q[$];

  function automatic logic m_irq();
    return (m_ien != 0) && ((m_ovf != 0) || (m_udf != 0) ||
           (m_thresh != 0 && m_q.size() >= m_thresh));
  endfunction

  function automatic logic [31:0] m_status();
    return (m_q.size() << 4) | (m_udf << 3) | (m_ovf << 2) |
           ((m_q.size() == DEPTH) << 1) | (m_q.size() == 0);
  endfunction

  task automatic m_reset();
    m_en = 0; m_ien = 0; m_thresh = 0; m_ovf = 0; m_udf = 0;
    m_q.delete();
  endtask

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; starts and ends on a falling edge so transfers may run back to back.
  task automatic apb_xfer(input logic wr, input logic [1:0] reg_i, input logic [31:0] wd,
                          output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_push, exp_pop, irq_before;
    exp_rd = 0; exp_push = 0; exp_pop = 0;
    irq_before = m_irq();
    if (wr) begin
      if (reg_i == 2 && m_en != 0) exp_push = (m_q.size() < DEPTH);
    end else begin
      case (reg_i)
        2'd0: exp_rd = (m_thresh << 4) | (m_ien << 1) | m_en;
        2'd1: exp_rd = m_status();
        2'd2: exp_rd = 0;
        2'd3: if (m_en != 0 && m_q.size() > 0) begin
                exp_pop = 1;
                exp_rd  = {24'b0, m_q[0]};
              end
        default: exp_rd = 0;
      endcase
    end

    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PADDR   = {reg_i, 2'($urandom_range(0, 3))};
    apb.PWRITE  = wr;
    apb.PWDATA  = wd;
    @(posedge clk); @(negedge clk);
    apb.PENABLE = 1'b1;
    check_val("pready_wait", apb.PREADY, 0);
    @(posedge clk); @(negedge clk);
    check_val("pready_resp", apb.PREADY, 1);
    check_val("wr_en_resp", fifo_wr_en, exp_push);
    check_val("rd_en_resp", fifo_rd_en, exp_pop);
    check_val("irq_lag", irq, irq_before);
    if (exp_push) check_val("wdata", fifo_wdata, wd[7:0]);
    if (!wr) check_val("prdata", apb.PRDATA, exp_rd);
    rd = apb.PRDATA;
    @(posedge clk); @(negedge clk);
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    check_val("pready_done", apb.PREADY, 0);
    check_val("strobes_done", {fifo_wr_en, fifo_rd_en}, 0);

    if (wr) begin
      case (reg_i)
        2'd0: begin m_en = wd[0]; m_ien = wd[1]; m_thresh = wd[8:4]; end
        2'd1: begin if (wd[2]) m_ovf = 0; if (wd[3]) m_udf = 0; end
        2'd2: if (m_en != 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(wd[7:0]); else m_ovf = 1;
              end
        default: ;
      endcase
    end else if (reg_i == 3 && m_en != 0) begin
      if (m_q.size() > 0) void'(m_q.pop_front()); else m_udf = 1;
    end
    check_val("irq", irq, m_irq());
  endtask

  logic [31:0] rd;

  initial begin
    apb.PSEL = 0; apb.PENABLE = 0; apb.PADDR = 0; apb.PWRITE = 0; apb.PWDATA = 0;
    m_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_outs", {apb.PRDATA, apb.PREADY, fifo_wr_en, fifo_rd_en, fifo_wdata, irq}, 0);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check_val("idle_outs", {apb.PREADY, fifo_wr_en, fifo_rd_en, irq}, 0);
    apb_xfer(0, 1, 0, rd);
    check_val("status_reset", rd, 32'h1);

    // Single push
    apb_xfer(1, 0, 32'h1, rd);
    apb_xfer(1, 2, 32'hFFFF_FFA5, rd);
    apb_xfer(0, 1, 0, rd);
    check_val("status_lvl1", rd, 32'h10);

    // Fill to full, then overflow
    for (int i = 0; i < 15; i++) apb_xfer(1, 2, $urandom, rd);
    apb_xfer(1, 2, 32'h77, rd);
    apb_xfer(0, 1, 0, rd);
    check_val("status_ovf", rd, 32'h106);
    apb_xfer(1, 1, 32'h4, rd);
    apb_xfer(0, 1, 0, rd);
    check_val("status_ovf_clr", rd, 32'h102);

    // Drain, then a known head byte, then underflow
    for (int i = 0; i < 16; i++) apb_xfer(0, 3, 0, rd);
    apb_xfer(1, 2, 32'h3C, rd);
    apb_xfer(0, 3, 0, rd);
    check_val("rx_head", rd, 32'h3C);
    apb_xfer(0, 3, 0, rd);
    check_val("rx_empty", rd, 32'h0);
    apb_xfer(0, 1, 0, rd);
    check_val("status_udf", rd, 32'h9);
    apb_xfer(1, 1, 32'h8, rd);

    // Level threshold interrupt
    apb_xfer(1, 0, 32'h43, rd);
    for (int i = 0; i < 4; i++) apb_xfer(1, 2, $urandom, rd);
    check_val("irq_thresh_hi", irq, 1);
    apb_xfer(0, 3, 0, rd);
    check_val("irq_thresh_lo", irq, 0);
    apb_xfer(1, 2, $urandom, rd);
    apb_xfer(1, 0, 32'h41, rd);
    check_val("irq_disabled", irq, 0);

    // Reset asserted in the RESP cycle of a push
    apb_xfer(1, 0, 32'h13, rd);
    check_val("irq_pre_rst", irq, 1);
    apb.PSEL = 1; apb.PENABLE = 0; apb.PADDR = 4'h8; apb.PWRITE = 1; apb.PWDATA = 32'h5A;
    @(posedge clk); @(negedge clk);
    apb.PENABLE = 1;
    @(posedge clk); @(negedge clk);
    check_val("resp_before_rst", {apb.PREADY, fifo_wr_en}, 2'b11);
    reset = 1'b0;
    #1;
    check_val("async_rst", {apb.PREADY, fifo_wr_en, irq}, 0);
    apb.PSEL = 0; apb.PENABLE = 0;
    m_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    apb_xfer(0, 1, 0, rd);
    check_val("status_post_rst", rd, 32'h1);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      int p;
      logic [31:0] d;
      p = $urandom_range(0, 99);
      d = $urandom;
      if (p < 35)      apb_xfer(1, 2, d, rd);
      else if (p < 65) apb_xfer(0, 3, d, rd);
      else if (p < 75) apb_xfer(0, 1, d, rd);
      else if (p < 82) apb_xfer(1, 1, d, rd);
      else if (p < 92) begin
        if ($urandom_range(0, 9) < 8) d[0] = 1'b1;
        apb_xfer(1, 0, d, rd);
      end
      else if (p < 96) apb_xfer(0, 0, d, rd);
      else             apb_xfer(p[0], p[0] ? 2'd3 : 2'd2, d, rd);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
